// File: rtl/seq_pattern_gen.sv
// Serial stimulus source for the Mealy "1101" detector: shifts a frame out MSB-first and
// drives the golden detect/count alongside each bit. Optional PRBS-7 idle fill: SEQ_GEN_PRBS_EN.
module seq_pattern_gen #(
    parameter int FRAME_W    = 16,
    parameter int LEN_W      = 5,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FRAME_W-1:0] frame_data,
    input  logic [LEN_W-1:0]   frame_len,
    input  logic               frame_valid,
`ifdef SEQ_GEN_PRBS_EN
    input  logic               prbs_en,
`endif
    output logic               frame_ready,
    output logic               ser_out,
    output logic               ser_valid,
    output logic               exp_detect,
    output logic               busy,
    output logic [CNT_W-1:0]   match_count
);
    localparam int IDX_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(FRAME_W);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    typedef enum logic [1:0] {S_IDLE, S_A, S_B, S_C} gst_t;

    state_t             r_state, w_nxt_state;
    gst_t               r_gst, w_nxt_gst, w_base;
    logic [FRAME_W-1:0] r_frame;
    logic [IDX_W-1:0]   r_idx, w_nxt_idx, w_fidx;
    logic [GAP_W-1:0]   r_gap, w_nxt_gap;
    logic               r_ready, r_bit, r_vld, r_det, r_busy;
    logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
    logic               w_accept, w_len_ok, w_load, w_emit, w_bit;
    logic               w_nxt_bit, w_nxt_vld, w_nxt_det;
    gst_t               w_step_gst;
    logic               w_step_det;
`ifdef SEQ_GEN_PRBS_EN
    logic [6:0]         r_lfsr, w_nxt_lfsr;
`endif

    assign w_accept = frame_valid && r_ready;
    assign w_len_ok = (frame_len != '0) && (frame_len <= MAX_LEN);
    assign w_fidx   = IDX_W'(frame_len - 1'b1);

    // One step of the reference "1101" Mealy machine (overlapping).
    always_comb begin
        w_step_gst = S_IDLE;
        w_step_det = 1'b0;
        case (w_base)
            S_IDLE: w_step_gst = w_bit ? S_A : S_IDLE;
            S_A:    w_step_gst = w_bit ? S_B : S_IDLE;
            S_B:    w_step_gst = w_bit ? S_B : S_C;
            S_C: begin
                w_step_gst = w_bit ? S_A : S_IDLE;
                w_step_det = w_bit;
            end
            default: w_step_gst = S_IDLE;
        endcase
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_gap   = r_gap;
        w_nxt_cnt   = r_cnt + CNT_W'(r_det && !(&r_cnt));
        w_load      = 1'b0;
        w_emit      = 1'b0;
        w_bit       = 1'b0;
`ifdef SEQ_GEN_PRBS_EN
        w_nxt_lfsr  = r_lfsr;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_len_ok) begin
                        w_load      = 1'b1;
                        w_emit      = 1'b1;
                        w_bit       = frame_data[w_fidx];
                        w_nxt_idx   = w_fidx;
                        w_nxt_cnt   = '0;
                        w_nxt_state = SHIFT;
                    end
                end
`ifdef SEQ_GEN_PRBS_EN
                else if (prbs_en) begin
                    w_emit     = 1'b1;
                    w_bit      = r_lfsr[6];
                    w_nxt_lfsr = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
                end
`endif
            end
            SHIFT: begin
                if (r_idx == '0) begin
                    w_nxt_state = (GAP_CYCLES == 0) ? IDLE : GAP;
                    w_nxt_gap   = GAP_W'(GAP_CYCLES - 1);
                end else begin
                    w_emit    = 1'b1;
                    w_bit     = r_frame[r_idx - 1'b1];
                    w_nxt_idx = r_idx - 1'b1;
                end
            end
            GAP: begin
                if (r_gap == '0) w_nxt_state = IDLE;
                else             w_nxt_gap   = r_gap - 1'b1;
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // A fresh frame always starts the model from S_IDLE, whatever idle fill preceded it.
    assign w_base    = w_load ? S_IDLE : r_gst;
    assign w_nxt_bit = w_emit && w_bit;
    assign w_nxt_vld = w_emit;
    assign w_nxt_det = w_emit && w_step_det;
    assign w_nxt_gst = w_emit ? w_step_gst : r_gst;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nxt_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gst   <= S_IDLE;
            r_frame <= '0;
            r_idx   <= '0;
            r_gap   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_bit   <= 1'b0;
            r_vld   <= 1'b0;
            r_det   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_gst   <= w_nxt_gst;
            if (w_load) r_frame <= frame_data;
            r_idx   <= w_nxt_idx;
            r_gap   <= w_nxt_gap;
            r_ready <= (w_nxt_state == IDLE);
            r_busy  <= (w_nxt_state != IDLE);
            r_bit   <= w_nxt_bit;
            r_vld   <= w_nxt_vld;
            r_det   <= w_nxt_det;
            r_cnt   <= w_nxt_cnt;
        end
    end

`ifdef SEQ_GEN_PRBS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_lfsr <= 7'h7F;
        else        r_lfsr <= w_nxt_lfsr;
    end
`endif

    assign frame_ready = r_ready;
    assign ser_out     = r_bit;
    assign ser_valid   = r_vld;
    assign exp_detect  = r_det;
    assign busy        = r_busy;
    assign match_count = r_cnt;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: expected bits/detects are queued per frame and
// popped by a negedge monitor whenever ser_valid is high.
module tb_seq_pattern_gen;
    logic        clk, reset;
    logic [15:0] frame_data;
    logic [4:0]  frame_len;
    logic        frame_valid, prbs_en;
    logic        frame_ready, ser_out, ser_valid, exp_detect, busy;
    logic [7:0]  match_count;

    typedef struct packed { logic ser; logic det; } exp_t;
    exp_t exp_q[$];
    int   total = 0, bad = 0;
    logic prbs_mode = 1'b0;
    logic [6:0] plfsr = 7'h7F;
    int   pst = 0;
    logic hist [0:253];
    int   hn = 0;

    seq_pattern_gen dut (
        .clk(clk), .reset(reset), .frame_data(frame_data), .frame_len(frame_len),
        .frame_valid(frame_valid),
`ifdef SEQ_GEN_PRBS_EN
        .prbs_en(prbs_en),
`endif
        .frame_ready(frame_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .exp_detect(exp_detect), .busy(busy), .match_count(match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference "1101" overlap detector, written from the state table.
    function automatic int gnext(input int s, input logic b, output logic det);
        det = (s == 3) && b;
        case (s)
            0: return b ? 1 : 0;
            1: return b ? 2 : 0;
            2: return b ? 2 : 3;
            default: return b ? 1 : 0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (ser_valid && prbs_mode) begin
                logic pb, pd;
                pb = plfsr[6];
                plfsr = {plfsr[5:0], plfsr[6] ^ plfsr[5]};
                pst = gnext(pst, pb, pd);
                if (hn < 254) begin hist[hn] = ser_out; hn++; end
                chk("prbs_bit", ser_out, pb);
                chk("prbs_det", exp_detect, pd);
            end else if (ser_valid) begin
                if (exp_q.size() == 0) chk("unexp_bit", ser_valid, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ser_out", ser_out, e.ser);
                    chk("exp_detect", exp_detect, e.det);
                end
            end else begin
                chk("idle_out", {ser_out, exp_detect}, 0);
            end
        end
    end

    task automatic send_frame(input logic [15:0] d, input int len);
        int st = 0, ndet = 0, cyc = 0;
        logic b, dt;
        for (int i = len - 1; i >= 0; i--) begin
            b  = d[i];
            st = gnext(st, b, dt);
            exp_q.push_back('{ser: b, det: dt});
            if (dt) ndet++;
        end
        @(posedge clk); #1;
        frame_data = d; frame_len = 5'(len); frame_valid = 1'b1;
        @(negedge clk); prbs_mode = 1'b0;
        @(posedge clk); #1;
        frame_valid = 1'b0; prbs_en = 1'b0;
        @(negedge clk);
        chk("latency", ser_valid, 1);
        while (!frame_ready && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        chk("rdy_low", cyc, len + 2);
        chk("count", match_count, ndet);
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic bad_len(input logic [4:0] l, input logic [7:0] cnt_exp);
        @(posedge clk); #1;
        frame_len = l; frame_data = 16'hFFFF; frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bad_vld", ser_valid, 0);
            chk("bad_rdy", frame_ready, 1);
        end
        chk("bad_cnt", match_count, cnt_exp);
    endtask

    initial begin
        reset = 1'b0; frame_data = '0; frame_len = '0; frame_valid = 1'b0; prbs_en = 1'b0;
        #12;
        chk("rst_ready", frame_ready, 1);
        chk("rst_out", {ser_out, ser_valid, exp_detect, busy}, 0);
        chk("rst_cnt", match_count, 0);
        @(negedge clk); reset = 1'b1;

        send_frame(16'h000D, 4);
        send_frame(16'h006D, 7);
        send_frame(16'h003B, 6);
        bad_len(5'd0, 8'd1);
        bad_len(5'd17, 8'd1);
        for (int k = 0; k < 4; k++)
            send_frame(16'($urandom), int'($urandom_range(1, 16)));

        // Reset lands while the third bit of 1101 is on the line.
        exp_q.push_back('{ser: 1'b1, det: 1'b0});
        exp_q.push_back('{ser: 1'b1, det: 1'b0});
        @(posedge clk); #1;
        frame_data = 16'h000D; frame_len = 5'd4; frame_valid = 1'b1;
        @(posedge clk); #1; frame_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_out", {ser_out, ser_valid, exp_detect, busy}, 0);
        chk("mid_rst_rdy", frame_ready, 1);
        chk("mid_rst_cnt", match_count, 0);
        chk("mid_rst_q", exp_q.size(), 0);
        @(negedge clk); reset = 1'b1;
        send_frame(16'h0005, 3);

`ifdef SEQ_GEN_PRBS_EN
        @(posedge clk); #1;
        prbs_mode = 1'b1; prbs_en = 1'b1;
        repeat (260) @(negedge clk);
        chk("prbs_hn", hn, 254);
        for (int i = 0; i < 127; i++) chk("prbs_period", hist[i + 127], hist[i]);
        send_frame(16'h000D, 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
